// File: rtl/alu_operand_port.sv
// ALU operand register: captures AC or IBUS, tracks operand validity with a consume
// handshake, and shifts the held operand one bit per clock for a programmable count.
module alu_operand_port #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk4,
    input  logic             nreset,
    input  logic [WIDTH-1:0] ac,
    input  logic [WIDTH-1:0] ibus,
    input  logic             sel,
    input  logic             load,
    input  logic             consume,
    input  logic             shift_start,
    input  logic             shift_dir,
    input  logic             shift_arith,
    input  logic [CNTW-1:0]  shift_count,
    output logic [WIDTH-1:0] a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] a_shifted;
    logic             fill_bit;

    // Right shifts fill with the MSB only when arithmetic mode is selected.
    assign fill_bit = shift_arith & a_q[WIDTH-1];

    always_comb begin
        a_shifted = a_q;
        if (shift_dir) begin
            a_shifted = {fill_bit, a_q[WIDTH-1:1]};
        end else begin
            a_shifted = {a_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        a_valid_d = a_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    a_d       = sel ? ibus : ac;
                    a_valid_d = 1'b1;
                end else if (shift_start) begin
                    if (shift_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = shift_count;
                        busy_d  = 1'b1;
                        state_d = StShift;
                    end
                end else if (consume) begin
                    a_valid_d = 1'b0;
                end
            end
            StShift: begin
                // load, consume and shift_start are deliberately ignored here.
                a_d   = a_shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alu_operand_port.sv
// Self-checking bench for alu_operand_port: directed scenarios plus random traffic
// compared every cycle against a shift-count-based reference model.
module tb_alu_operand_port;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk4 = 1'b0;
    logic          nreset;
    logic [W-1:0]  ac, ibus;
    logic          sel, load, consume, shift_start, shift_dir, shift_arith;
    logic [CW-1:0] shift_count;
    logic [W-1:0]  a;
    logic          a_valid, busy, done;

    always #5 clk4 = ~clk4;

    alu_operand_port #(
        .WIDTH(W),
        .CNTW (CW)
    ) dut (
        .clk4       (clk4),
        .nreset     (nreset),
        .ac         (ac),
        .ibus       (ibus),
        .sel        (sel),
        .load       (load),
        .consume    (consume),
        .shift_start(shift_start),
        .shift_dir  (shift_dir),
        .shift_arith(shift_arith),
        .shift_count(shift_count),
        .a          (a),
        .a_valid    (a_valid),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: operand value, validity, and an in-flight shift described by the
    // original operand, shifts completed so far and shifts remaining.
    logic [W-1:0] m_a, m_orig;
    logic         m_valid, m_done, m_dir, m_arith;
    int           m_rem, m_k;

    function automatic logic [W-1:0] shifted(logic [W-1:0] v, int k, logic dir, logic arith);
        logic signed [W-1:0] sv;
        sv = $signed(v);
        if (!dir) return v << k;
        if (arith) return sv >>> k;
        return v >> k;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_orig = '0; m_valid = 1'b0; m_done = 1'b0;
        m_dir = 1'b0; m_arith = 1'b0; m_rem = 0; m_k = 0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (m_rem > 0) begin
            m_k++;
            m_rem--;
            m_a = shifted(m_orig, m_k, m_dir, m_arith);
            if (m_rem == 0) m_done = 1'b1;
        end else if (load) begin
            m_a     = sel ? ibus : ac;
            m_valid = 1'b1;
        end else if (shift_start) begin
            if (shift_count == 0) begin
                m_done = 1'b1;
            end else begin
                m_rem   = int'(shift_count);
                m_k     = 0;
                m_orig  = m_a;
                m_dir   = shift_dir;
                m_arith = shift_arith;
            end
        end else if (consume) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_a"}, 32'(a), 32'(m_a));
        check_eq({tag, "_valid"}, 32'(a_valid), 32'(m_valid));
        check_eq({tag, "_busy"}, 32'(busy), 32'(m_rem > 0));
        check_eq({tag, "_done"}, 32'(done), 32'(m_done));
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic cycle(input string tag);
        @(posedge clk4);
        if (nreset) model_edge();
        @(negedge clk4);
        check_outputs(tag);
    endtask

    task automatic quiet();
        load = 1'b0; consume = 1'b0; shift_start = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        ac = v; sel = 1'b0; load = 1'b1;
        cycle("load");
        load = 1'b0;
    endtask

    task automatic start_shift(input logic dir, input logic arith, input int cnt);
        shift_dir = dir; shift_arith = arith; shift_count = CW'(cnt); shift_start = 1'b1;
        cycle("start");
        shift_start = 1'b0;
    endtask

    initial begin
        nreset = 1'b0;
        ac = '0; ibus = '0; sel = 1'b0;
        quiet();
        shift_dir = 1'b0; shift_arith = 1'b0; shift_count = '0;
        model_reset();
        repeat (2) @(negedge clk4);
        check_outputs("reset");
        nreset = 1'b1;

        // 1: load from ac, then consume
        ac = 16'h1234; sel = 1'b0; load = 1'b1;
        cycle("t1_load");
        load = 1'b0;
        check_eq("t1_a_const", 32'(a), 32'h1234);
        check_eq("t1_valid_const", 32'(a_valid), 32'h1);
        consume = 1'b1;
        cycle("t1_consume");
        consume = 1'b0;
        check_eq("t1_consumed", 32'(a_valid), 32'h0);
        check_eq("t1_a_kept", 32'(a), 32'h1234);

        // 2: load and consume on the same edge
        ibus = 16'hBEEF; sel = 1'b1; load = 1'b1; consume = 1'b1;
        cycle("t2");
        quiet();
        check_eq("t2_a_const", 32'(a), 32'hBEEF);
        check_eq("t2_valid_const", 32'(a_valid), 32'h1);

        // 3: left shift by 4 with a load attempted mid-shift
        do_load(16'h0001);
        start_shift(1'b0, 1'b0, 4);
        ac = 16'hFFFF; sel = 1'b0; load = 1'b1;
        repeat (3) cycle("t3_run");
        check_eq("t3_busy_before_last", 32'(busy), 32'h1);
        cycle("t3_last");
        load = 1'b0;
        check_eq("t3_a_const", 32'(a), 32'h0010);
        check_eq("t3_done_const", 32'(done), 32'h1);
        check_eq("t3_busy_low", 32'(busy), 32'h0);
        cycle("t3_after");
        check_eq("t3_done_drop", 32'(done), 32'h0);

        // 4: right shifts on 8000, arithmetic then logical
        do_load(16'h8000);
        start_shift(1'b1, 1'b1, 3);
        repeat (3) cycle("t4_arith");
        check_eq("t4_arith_const", 32'(a), 32'hF000);
        do_load(16'h8000);
        start_shift(1'b1, 1'b0, 3);
        repeat (3) cycle("t4_logic");
        check_eq("t4_logic_const", 32'(a), 32'h1000);

        // 5: zero count, then a 15-bit left shift of all ones
        do_load(16'hC3A5);
        start_shift(1'b0, 1'b0, 0);
        check_eq("t5_zero_done", 32'(done), 32'h1);
        check_eq("t5_zero_busy", 32'(busy), 32'h0);
        check_eq("t5_zero_a", 32'(a), 32'hC3A5);
        cycle("t5_zero_after");
        do_load(16'hFFFF);
        start_shift(1'b0, 1'b0, 15);
        repeat (15) cycle("t5_long");
        check_eq("t5_long_const", 32'(a), 32'h8000);

        // 6: reset between edges in the middle of a 10-count shift
        do_load(16'h00FF);
        start_shift(1'b0, 1'b0, 10);
        repeat (4) cycle("t6_run");
        nreset = 1'b0;
        #1;
        model_reset();
        check_eq("t6_rst_a", 32'(a), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        check_eq("t6_rst_valid", 32'(a_valid), 32'h0);
        cycle("t6_held");
        nreset = 1'b1;
        repeat (8) cycle("t6_idle");
        do_load(16'h5A5A);
        check_eq("t6_reload", 32'(a), 32'h5A5A);

        // Random traffic; direction and mode held steady while a shift is in flight
        for (int i = 0; i < 600; i++) begin
            ac   = W'($urandom);
            ibus = W'($urandom);
            sel  = 1'($urandom);
            load        = ($urandom_range(0, 3) == 0);
            consume     = ($urandom_range(0, 3) == 0);
            shift_start = ($urandom_range(0, 2) == 0);
            shift_count = ($urandom_range(0, 4) == 0) ? CW'(0) : CW'($urandom);
            if (m_rem == 0) begin
                shift_dir   = 1'($urandom);
                shift_arith = 1'($urandom);
            end
            cycle("rand");
        end
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
